// File: rtl/median_ctrl_pkg.sv
// Shared types for the median frame sequencer.
// State encoding and error flag bit positions.
package median_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACTIVE,
    PAD,
    DISCARD,
    FLUSH
  } ctrl_state_t;

  localparam int ERR_SHORT   = 0;
  localparam int ERR_LONG    = 1;
  localparam int ERR_NO_SOF  = 2;
  localparam int ERR_MID_SOF = 3;

endpackage

// File: rtl/median_axis_out_reg.sv
// Single-stage AXI-Stream output register toward the median core.
// Loads whenever empty or being drained; holds stable under stall.
module median_axis_out_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         nxt_valid,
  input  logic [N-1:0] nxt_data,
  input  logic         nxt_user,
  input  logic         nxt_last,
  input  logic         nxt_pad,
  output logic         load_en,
  output logic [N-1:0] tdata,
  output logic         tvalid,
  input  logic         tready,
  output logic         tuser,
  output logic         tlast,
  output logic         pad
);

  assign load_en = ~tvalid | tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tuser  <= 1'b0;
      tlast  <= 1'b0;
      pad    <= 1'b0;
    end else if (load_en) begin
      tvalid <= nxt_valid;
      if (nxt_valid) begin
        tdata <= nxt_data;
        tuser <= nxt_user;
        tlast <= nxt_last;
        pad   <= nxt_pad;
      end
    end
  end

endmodule

// File: rtl/median_frame_ctrl.sv
// Frame sequencer ahead of the 5x5 median core: repairs line
// geometry, appends flush lines and reports errors.
module median_frame_ctrl
  import median_ctrl_pkg::*;
#(
  parameter int N           = 8,
  parameter int WIDTH       = 10,
  parameter int HEIGHT      = 10,
  parameter int FLUSH_LINES = 2,
  parameter int CNT_W       = 13
) (
  input  logic         sys_clk,
  input  logic         sys_areset,
  input  logic [N-1:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tuser,
  input  logic         s_axis_tlast,
  output logic [N-1:0] m_core_tdata,
  output logic         m_core_tvalid,
  input  logic         m_core_tready,
  output logic         m_core_tuser,
  output logic         m_core_tlast,
  output logic         m_core_pad,
  output logic         core_lb_clear,
  output logic         frame_done,
  output logic [3:0]   err_flags
);

  localparam logic [CNT_W-1:0] PIX_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LINE_LAST  = CNT_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] LINE_END   = CNT_W'(HEIGHT);
  localparam logic [CNT_W-1:0] FLUSH_LAST =
    CNT_W'(HEIGHT + FLUSH_LINES - 1);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic [CNT_W-1:0] pos_p, pos_l;
  logic [3:0]       err_q, err_d;
  logic             clr_q, clr_d;
  logic             done_q, done_d;
  logic             load_en, accepting, acc, fwd;
  logic             emit, o_user, o_last, o_pad;
  logic [N-1:0]     o_data;

  assign accepting = (state_q == IDLE) |
                     (state_q == ACTIVE) |
                     (state_q == DISCARD);
  assign s_axis_tready = ~sys_areset & load_en & accepting;
  assign acc = s_axis_tvalid & s_axis_tready;

  assign core_lb_clear = clr_q;
  assign err_flags     = err_q;
  assign frame_done    = m_core_tvalid & m_core_tready & done_q;

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    line_d  = line_q;
    err_d   = err_q;
    clr_d   = 1'b0;
    done_d  = load_en ? 1'b0 : done_q;
    emit    = 1'b0;
    fwd     = 1'b0;
    o_data  = s_axis_tdata;
    o_user  = 1'b0;
    o_last  = 1'b0;
    o_pad   = 1'b0;
    pos_p   = pix_q;
    pos_l   = line_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          if (s_axis_tuser) fwd = 1'b1;
          else err_d[ERR_NO_SOF] = 1'b1;
        end
      end
      ACTIVE: begin
        if (acc) fwd = 1'b1;
      end
      DISCARD: begin
        if (acc) begin
          if (s_axis_tuser) begin
            fwd = 1'b1;
          end else if (s_axis_tlast) begin
            state_d = (line_q == LINE_END) ? FLUSH : ACTIVE;
          end
        end
      end
      PAD: begin
        if (load_en) begin
          // m_core_tdata still holds the last forwarded pixel
          emit   = 1'b1;
          o_data = m_core_tdata;
          o_pad  = 1'b1;
          o_last = (pix_q == PIX_LAST);
          if (o_last) begin
            pix_d   = '0;
            line_d  = line_q + 1'b1;
            state_d = (line_q == LINE_LAST) ? FLUSH : ACTIVE;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (load_en) begin
          emit   = 1'b1;
          o_data = '0;
          o_pad  = 1'b1;
          o_last = (pix_q == PIX_LAST);
          if (o_last && line_q == FLUSH_LAST) begin
            pix_d   = '0;
            line_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (o_last) begin
            pix_d  = '0;
            line_d = line_q + 1'b1;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fwd) begin
      emit = 1'b1;
      if (s_axis_tuser) begin
        // SOF restarts counting from this beat
        o_user = 1'b1;
        clr_d  = 1'b1;
        pos_p  = '0;
        pos_l  = '0;
        if (pix_q != '0 || line_q != '0) err_d[ERR_MID_SOF] = 1'b1;
      end
      o_last = (pos_p == PIX_LAST);
      if (pos_p == PIX_LAST) begin
        pix_d  = '0;
        line_d = pos_l + 1'b1;
        if (s_axis_tlast) begin
          state_d = (pos_l == LINE_LAST) ? FLUSH : ACTIVE;
        end else begin
          err_d[ERR_LONG] = 1'b1;
          state_d = DISCARD;
        end
      end else begin
        pix_d  = pos_p + 1'b1;
        line_d = pos_l;
        if (s_axis_tlast) begin
          err_d[ERR_SHORT] = 1'b1;
          state_d = PAD;
        end else begin
          state_d = ACTIVE;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_areset) begin
    if (sys_areset) begin
      state_q <= IDLE;
      pix_q   <= '0;
      line_q  <= '0;
      err_q   <= '0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      err_q   <= err_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

  median_axis_out_reg #(.N(N)) u_out (
    .clk       (sys_clk),
    .rst       (sys_areset),
    .nxt_valid (emit),
    .nxt_data  (o_data),
    .nxt_user  (o_user),
    .nxt_last  (o_last),
    .nxt_pad   (o_pad),
    .load_en   (load_en),
    .tdata     (m_core_tdata),
    .tvalid    (m_core_tvalid),
    .tready    (m_core_tready),
    .tuser     (m_core_tuser),
    .tlast     (m_core_tlast),
    .pad       (m_core_pad)
  );

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Scoreboard bench for median_frame_ctrl: a line-level reference
// model fills an expectation queue, a monitor pops and compares.
module tb_median_frame_ctrl;
  import median_ctrl_pkg::*;

  localparam int W  = 10;
  localparam int H  = 10;
  localparam int FL = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       u;
    logic       l;
  } ibeat_t;

  typedef struct packed {
    logic [7:0] d;
    logic       u;
    logic       l;
    logic       p;
  } obeat_t;

  logic       sys_clk = 1'b0;
  logic       sys_areset = 1'b1;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       s_axis_tuser = 1'b0;
  logic       s_axis_tlast = 1'b0;
  logic [7:0] m_core_tdata;
  logic       m_core_tvalid;
  logic       m_core_tready = 1'b1;
  logic       m_core_tuser;
  logic       m_core_tlast;
  logic       m_core_pad;
  logic       core_lb_clear;
  logic       frame_done;
  logic [3:0] err_flags;

  median_frame_ctrl #(
    .N(8), .WIDTH(W), .HEIGHT(H), .FLUSH_LINES(FL), .CNT_W(13)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_areset    (sys_areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .m_core_tdata  (m_core_tdata),
    .m_core_tvalid (m_core_tvalid),
    .m_core_tready (m_core_tready),
    .m_core_tuser  (m_core_tuser),
    .m_core_tlast  (m_core_tlast),
    .m_core_pad    (m_core_pad),
    .core_lb_clear (core_lb_clear),
    .frame_done    (frame_done),
    .err_flags     (err_flags)
  );

  always #5 sys_clk = ~sys_clk;

  bit rnd_ready = 1'b0;
  always @(posedge sys_clk) begin
    #1;
    m_core_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  ibeat_t     stim_q[$];
  obeat_t     exp_q[$];
  logic [3:0] exp_err;
  int         exp_frames, exp_sofs;
  int         done_cnt, clr_cnt, base_done, base_clr;
  int         n_checks, n_fail;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    obeat_t cur, prev, e;
    bit     prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge sys_clk);
      cur = '{m_core_tdata, m_core_tuser, m_core_tlast, m_core_pad};
      if (sys_areset) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall)
        check("stall_hold", {m_core_tvalid, cur}, {1'b1, prev});
      if (frame_done) done_cnt++;
      if (core_lb_clear) clr_cnt++;
      if (m_core_tvalid && m_core_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h, expected none", cur);
        end else begin
          e = exp_q.pop_front();
          check("beat", cur, e);
        end
      end
      prev_stall = m_core_tvalid && !m_core_tready;
      prev = cur;
    end
  endtask

  // Reference: split input into lines and frames, then repair each line
  task automatic run_model();
    int         i, len;
    bit         ended, restart, incomplete;
    logic [7:0] lastpx;
    i = 0;
    incomplete = 1'b0;
    while (i < stim_q.size() && !incomplete) begin
      if (!stim_q[i].u) begin
        exp_err[ERR_NO_SOF] = 1'b1;
        i++;
      end else begin
        exp_sofs++;
        restart = 1'b0;
        for (int ln = 0; ln < H && !restart && !incomplete; ln++) begin
          len = 0;
          ended = 1'b0;
          lastpx = '0;
          while (!ended && !restart && i < stim_q.size()) begin
            if (stim_q[i].u && (ln != 0 || len != 0)) begin
              restart = 1'b1;
              exp_err[ERR_MID_SOF] = 1'b1;
            end else begin
              if (len < W) begin
                exp_q.push_back('{stim_q[i].d, (ln == 0 && len == 0),
                                  (len == W - 1), 1'b0});
                lastpx = stim_q[i].d;
              end
              if (len == W - 1 && !stim_q[i].l) exp_err[ERR_LONG] = 1'b1;
              ended = stim_q[i].l;
              len++;
              i++;
            end
          end
          if (!ended && !restart) begin
            incomplete = 1'b1;
          end else if (ended && len < W) begin
            exp_err[ERR_SHORT] = 1'b1;
            for (int j = len; j < W; j++)
              exp_q.push_back('{lastpx, 1'b0, (j == W - 1), 1'b1});
          end
        end
        if (!restart && !incomplete) begin
          for (int j = 0; j < FL * W; j++)
            exp_q.push_back('{8'h00, 1'b0, ((j % W) == W - 1), 1'b1});
          exp_frames++;
        end
      end
    end
  endtask

  task automatic add_line(input int len, input bit sof, input bit last);
    for (int k = 0; k < len; k++)
      stim_q.push_back('{8'($urandom_range(0, 255)), (sof && k == 0),
                         (last && k == len - 1)});
  endtask

  task automatic add_frame();
    add_line(W, 1'b1, 1'b1);
    repeat (H - 1) add_line(W, 1'b0, 1'b1);
  endtask

  task automatic send(input ibeat_t b);
    bit ok;
    int t;
    if ($urandom_range(0, 3) == 0) begin
      s_axis_tvalid = 1'b0;
      @(posedge sys_clk);
      #1;
    end
    s_axis_tdata  = b.d;
    s_axis_tuser  = b.u;
    s_axis_tlast  = b.l;
    s_axis_tvalid = 1'b1;
    ok = 1'b0;
    t = 0;
    while (!ok && t < 1000) begin
      @(negedge sys_clk);
      ok = s_axis_tready;
      @(posedge sys_clk);
      #1;
      t++;
    end
    if (!ok) check("input_timeout", 32'(ok), 32'd1);
  endtask

  task automatic drive_all();
    foreach (stim_q[k]) send(stim_q[k]);
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 5000 && exp_q.size() != 0; k++)
      @(posedge sys_clk);
    check("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (4) @(posedge sys_clk);
    #1;
  endtask

  task automatic apply_reset();
    sys_areset = 1'b1;
    s_axis_tvalid = 1'b0;
    #1;
    check("reset_outputs",
          32'({m_core_tvalid, m_core_tdata, m_core_tuser, m_core_tlast,
               m_core_pad, core_lb_clear, frame_done, err_flags,
               s_axis_tready}), 32'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    exp_q.delete();
    sys_areset = 1'b0;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic begin_case();
    stim_q.delete();
    exp_err = '0;
    exp_frames = 0;
    exp_sofs = 0;
    base_done = done_cnt;
    base_clr = clr_cnt;
  endtask

  task automatic end_case(input string tag);
    run_model();
    drive_all();
    drain();
    check({tag, "_err_flags"}, 32'(err_flags), 32'(exp_err));
    check({tag, "_frame_done"}, 32'(done_cnt - base_done), 32'(exp_frames));
    check({tag, "_lb_clear"}, 32'(clr_cnt - base_clr), 32'(exp_sofs));
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    done_cnt = 0;
    clr_cnt = 0;
    fork
      monitor();
    join_none
    for (int t = 1; t <= 6; t++) begin
      apply_reset();
      begin_case();
      rnd_ready = (t == 6);
      case (t)
        2: begin
          add_line(8, 1'b1, 1'b1);
          repeat (H - 1) add_line(W, 1'b0, 1'b1);
        end
        3: begin
          add_line(13, 1'b1, 1'b1);
          repeat (H - 1) add_line(W, 1'b0, 1'b1);
        end
        4: begin
          add_line(3, 1'b0, 1'b0);
          add_frame();
        end
        5: begin
          add_line(W, 1'b1, 1'b1);
          add_line(W, 1'b0, 1'b1);
          add_line(W, 1'b0, 1'b1);
          add_line(4, 1'b0, 1'b0);
          add_frame();
        end
        default: add_frame();
      endcase
      end_case($sformatf("t%0d", t));
      if (t == 6) begin
        begin_case();
        add_line(W, 1'b1, 1'b1);
        repeat (4) add_line(W, 1'b0, 1'b1);
        add_line(5, 1'b0, 1'b0);
        run_model();
        drive_all();
        apply_reset();
        begin_case();
        add_frame();
        end_case("t6_after_reset");
      end
    end
    rnd_ready = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
